decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Decoupled, parametrised decode stage for the 3-bit machine (ADV..CDV).
//  Accepts {opcode, operand} from fetch via valid/ready and decodes each one
//  into a micro-op: op1/op2/operation selects, one-hot write enables, and an
//  illegal-combo flag. Buffers micro-ops in a DEPTH-entry FIFO for the execute
//  stage, with a flush input for taken jumps.
// PARAMETERS
//  DEPTH       2  micro-op FIFO entries (>=1)
//  STICKY_SEL  1  1: unused op1/op2/operation fields keep last pushed value; 0: unused fields = 0
//  CW          $clog2(DEPTH+1)  occupancy width (derived, localparam)
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   reset, asynchronous, active-low
//  flush             in   1   discard all queued entries and any same-cycle push
//  in_valid          in   1   fetch presents an instruction
//  in_ready          out  1   decode accepts (combinational)
//  in_opcode         in   3   opcode 0..7
//  in_operand        in   3   operand 0..7
//  out_valid         out  1   head micro-op valid
//  out_ready         in   1   execute consumes head
//  out_operand       out  3   operand of head
//  out_op1_sel       out  2   0 COMBO_OP, 1 REG_B, 2 REG_C, 3 LIT_OP
//  out_op2_sel       out  2   same encoding as op1
//  out_operation_sel out  2   0 SHIFT, 1 XOR, 2 MOD, 3 JUMP
//  out_reg_wr_en     out  5   one-hot [0]A [1]B [2]C [3]OUT [4]PC
//  out_illegal       out  1   head uses combo operand 7
//  occupancy         out  CW  entries held
// BEHAVIOUR
//  Reset: FIFO empty, out_valid=0, occupancy=0, in_ready=1, sticky regs=0;
//   all out_* data fields 0 while empty.
//  Decode table (op1, op2, operation, wr_en):
//   ADV: -,-,SHIFT,A   BXL: B,LIT,XOR,B   BST: B,-,MOD,B   JNZ: -,-,JUMP,PC
//   BXC: B,C,XOR,B     OUT: COMBO,-,MOD,OUT  BDV: -,-,SHIFT,B  CDV: -,-,SHIFT,C
//   '-' = sticky value (STICKY_SEL=1) or 0 (STICKY_SEL=0).
//  Sticky regs hold the op1/op2/operation of the last accepted, unflushed push;
//   reset to 0; flush does not clear them.
//  Illegal: ADV/BDV/CDV/OUT with operand 7 -> entry enqueued, illegal=1, wr_en=0.
//   BST with operand 7 is also illegal (combo source).
//  Push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
//  in_ready = (occupancy < DEPTH) | out_ready. Push and pop in the same cycle
//   when full is allowed; occupancy is unchanged.
//  Latency: an instruction accepted at edge N appears at the head at N+1
//   (out_valid=1 after N) if the FIFO was empty or drained.
//  Head data is stable while out_valid & !out_ready.
//  Order is strict FIFO; pointers wrap modulo DEPTH (non-power-of-2 allowed).
//  flush: at the next edge occupancy=0, out_valid=0; same-cycle push and pop
//   are ignored; in_ready is still driven.
//  Async reset mid-operation empties the FIFO immediately.
// TESTING
//  1 Reset -> out_valid=0, occupancy=0, in_ready=1, all out_* = 0.
//  2 Push BXL op 5 into empty -> next cycle out_op1=1, op2=3, operation=1,
//    wr_en=5'b00010, out_operand=5.
//  3 DEPTH=2, out_ready=0, push 3 instrs -> third stalls (in_ready=0),
//    occupancy=2; raise out_ready -> order preserved, no loss or duplication.
//  4 Full FIFO, out_ready=1, in_valid=1 -> push+pop same edge, occupancy stays 2.
//  5 flush with in_valid=1, occupancy=2 -> next cycle occupancy=0 and the
//    pushed instruction is absent.
//  6 OUT op 7 -> out_illegal=1, wr_en=0. With STICKY_SEL=1, BXC then ADV ->
//    ADV shows op1=1, op2=2; with STICKY_SEL=0 -> op1=0, op2=0.

Source files
------------

// File: rtl/decode_queue.sv
// Decode stage for the 3-bit machine: decodes {opcode, operand} into a micro-op
// and queues it in a DEPTH-entry FIFO (valid/ready both sides, flush on jumps).
//
// Ports: clk, rst_n (async, active-low), flush
//   fetch side  : in_valid, in_ready, in_opcode[2:0], in_operand[2:0]
//   execute side: out_valid, out_ready, out_operand[2:0], out_op1_sel[1:0],
//                 out_op2_sel[1:0], out_operation_sel[1:0], out_reg_wr_en[4:0],
//                 out_illegal, occupancy[CW-1:0]
module decode_queue #(
  parameter int DEPTH      = 2,
  parameter bit STICKY_SEL = 1'b1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [2:0]    in_operand,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_operand,
  output logic [1:0]    out_op1_sel,
  output logic [1:0]    out_op2_sel,
  output logic [1:0]    out_operation_sel,
  output logic [4:0]    out_reg_wr_en,
  output logic          out_illegal,
  output logic [CW-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_ADV = 3'd0;
  localparam logic [2:0] OP_BXL = 3'd1;
  localparam logic [2:0] OP_BST = 3'd2;
  localparam logic [2:0] OP_JNZ = 3'd3;
  localparam logic [2:0] OP_BXC = 3'd4;
  localparam logic [2:0] OP_OUT = 3'd5;
  localparam logic [2:0] OP_BDV = 3'd6;
  localparam logic [2:0] OP_CDV = 3'd7;

  localparam logic [1:0] SEL_COMBO = 2'd0;
  localparam logic [1:0] SEL_B     = 2'd1;
  localparam logic [1:0] SEL_C     = 2'd2;
  localparam logic [1:0] SEL_LIT   = 2'd3;

  localparam logic [1:0] OPN_SHIFT = 2'd0;
  localparam logic [1:0] OPN_XOR   = 2'd1;
  localparam logic [1:0] OPN_MOD   = 2'd2;
  localparam logic [1:0] OPN_JUMP  = 2'd3;

  localparam logic [4:0] WR_A   = 5'b00001;
  localparam logic [4:0] WR_B   = 5'b00010;
  localparam logic [4:0] WR_C   = 5'b00100;
  localparam logic [4:0] WR_OUT = 5'b01000;
  localparam logic [4:0] WR_PC  = 5'b10000;

  typedef struct packed {
    logic [2:0] operand;
    logic [1:0] op1;
    logic [1:0] op2;
    logic [1:0] opn;
    logic [4:0] wr;
    logic       ill;
  } uop_t;

  uop_t          mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    s1_q, s1_d;
  logic [1:0]    s2_q, s2_d;

  uop_t uop;
  uop_t head;
  logic combo;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    uop         = '0;
    uop.operand = in_operand;
    uop.op1     = STICKY_SEL ? s1_q : 2'd0;
    uop.op2     = STICKY_SEL ? s2_q : 2'd0;
    uop.opn     = OPN_SHIFT;
    combo       = 1'b0;
    unique case (in_opcode)
      OP_ADV: begin
        uop.wr = WR_A;
        combo  = 1'b1;
      end
      OP_BXL: begin
        uop.op1 = SEL_B;
        uop.op2 = SEL_LIT;
        uop.opn = OPN_XOR;
        uop.wr  = WR_B;
      end
      OP_BST: begin
        uop.op1 = SEL_B;
        uop.opn = OPN_MOD;
        uop.wr  = WR_B;
        combo   = 1'b1;
      end
      OP_JNZ: begin
        uop.opn = OPN_JUMP;
        uop.wr  = WR_PC;
      end
      OP_BXC: begin
        uop.op1 = SEL_B;
        uop.op2 = SEL_C;
        uop.opn = OPN_XOR;
        uop.wr  = WR_B;
      end
      OP_OUT: begin
        uop.op1 = SEL_COMBO;
        uop.opn = OPN_MOD;
        uop.wr  = WR_OUT;
        combo   = 1'b1;
      end
      OP_BDV: begin
        uop.wr = WR_B;
        combo  = 1'b1;
      end
      OP_CDV: begin
        uop.wr = WR_C;
        combo  = 1'b1;
      end
    endcase
    // combo operand 7 is reserved: keep the entry but suppress writes
    if (combo && in_operand == 3'd7) begin
      uop.ill = 1'b1;
      uop.wr  = '0;
    end
  end

  always_comb begin
    out_valid = (cnt_q != '0);
    in_ready  = (cnt_q < CW'(DEPTH)) | out_ready;
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
    rd_d      = pop ? nxt(rd_q) : rd_q;
    wr_d      = push ? nxt(wr_q) : wr_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    s1_d      = push ? uop.op1 : s1_q;
    s2_d      = push ? uop.op2 : s2_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= uop;
  end

  // empty queue presents all-zero data
  assign head              = out_valid ? mem_q[rd_q] : '0;
  assign out_operand       = head.operand;
  assign out_op1_sel       = head.op1;
  assign out_op2_sel       = head.op2;
  assign out_operation_sel = head.opn;
  assign out_reg_wr_en     = head.wr;
  assign out_illegal       = head.ill;
  assign occupancy         = cnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus random traffic against
// a queue-based reference model; two instances (sticky on / sticky off).
module tb_decode_queue;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_opcode = '0;
  logic [2:0] in_operand = '0;
  logic       out_ready = 1'b0;

  logic       a_ready, a_valid, a_ill;
  logic [2:0] a_operand;
  logic [1:0] a_op1, a_op2, a_opn, a_occ;
  logic [4:0] a_wr;
  logic       b_ready, b_valid, b_ill;
  logic [2:0] b_operand;
  logic [1:0] b_op1, b_op2, b_opn, b_occ;
  logic [4:0] b_wr;

  logic [18:0] obs_a, obs_b;
  assign obs_a = {a_valid, a_ready, a_occ, a_operand,
                  a_op1, a_op2, a_opn, a_wr, a_ill};
  assign obs_b = {b_valid, b_ready, b_occ, b_operand,
                  b_op1, b_op2, b_opn, b_wr, b_ill};

  decode_queue #(.DEPTH(DEPTH), .STICKY_SEL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_opcode(in_opcode), .in_operand(in_operand),
    .out_valid(a_valid), .out_ready(out_ready),
    .out_operand(a_operand), .out_op1_sel(a_op1),
    .out_op2_sel(a_op2), .out_operation_sel(a_opn),
    .out_reg_wr_en(a_wr), .out_illegal(a_ill),
    .occupancy(a_occ)
  );

  decode_queue #(.DEPTH(DEPTH), .STICKY_SEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_opcode(in_opcode), .in_operand(in_operand),
    .out_valid(b_valid), .out_ready(out_ready),
    .out_operand(b_operand), .out_op1_sel(b_op1),
    .out_op2_sel(b_op2), .out_operation_sel(b_opn),
    .out_reg_wr_en(b_wr), .out_illegal(b_ill),
    .occupancy(b_occ)
  );

  always #5 clk = ~clk;

  // decode table, -1 = field not used by the instruction
  int T_OP1 [8] = '{-1, 1, 1, -1, 1, 0, -1, -1};
  int T_OP2 [8] = '{-1, 3, -1, -1, 2, -1, -1, -1};
  int T_OPN [8] = '{0, 1, 2, 3, 1, 2, 0, 0};
  int T_WR  [8] = '{0, 1, 1, 4, 1, 3, 1, 2};
  bit T_CMB [8] = '{1, 0, 1, 0, 0, 1, 1, 1};

  typedef struct {
    int opc;
    int opr;
    int s1;
    int s2;
  } ent_t;

  ent_t q[$];
  int   m_s1 = 0;
  int   m_s2 = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [14:0] fields(ent_t e, bit sticky);
    int o1, o2;
    bit ill;
    logic [4:0] wr;
    o1 = T_OP1[e.opc];
    o2 = T_OP2[e.opc];
    if (o1 < 0) o1 = sticky ? e.s1 : 0;
    if (o2 < 0) o2 = sticky ? e.s2 : 0;
    ill = T_CMB[e.opc] && (e.opr == 7);
    wr = ill ? 5'd0 : 5'(1 << T_WR[e.opc]);
    return {3'(e.opr), 2'(o1), 2'(o2), 2'(T_OPN[e.opc]), wr, ill};
  endfunction

  function automatic logic [18:0] expect_bundle(bit sticky);
    int n;
    logic rdy;
    logic [14:0] f;
    n = q.size();
    rdy = (n < DEPTH) || out_ready;
    f = (n > 0) ? fields(q[0], sticky) : 15'd0;
    return {n > 0, rdy, 2'(n), f};
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1 = 0;
    m_s2 = 0;
  endtask

  task automatic model_edge();
    int n;
    bit rdy, push, pop;
    ent_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n = q.size();
    rdy = (n < DEPTH) || out_ready;
    push = in_valid && rdy && !flush;
    pop = (n > 0) && out_ready && !flush;
    if (flush) begin
      q.delete();
      return;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      e.opc = int'(in_opcode);
      e.opr = int'(in_operand);
      e.s1 = m_s1;
      e.s2 = m_s2;
      q.push_back(e);
      if (T_OP1[e.opc] >= 0) m_s1 = T_OP1[e.opc];
      if (T_OP2[e.opc] >= 0) m_s2 = T_OP2[e.opc];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(bit v, int opc, int opr, bit rdy, bit fl);
    in_valid = v;
    in_opcode = 3'(opc);
    in_operand = 3'(opr);
    out_ready = rdy;
    flush = fl;
  endtask

  task automatic drain();
    drive(0, 0, 0, 1, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #3;
    n_checks++;
    if (a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", a_valid);
    end
    n_checks++;
    if (a_occ !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_occ got %0d want 0", a_occ);
    end
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 1", a_ready);
    end
    n_checks++;
    if (obs_a[14:0] !== 15'd0 || obs_b[14:0] !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 0", obs_a[14:0], obs_b[14:0]);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bxl();
    drive(1, 1, 5, 0, 0);
    #3;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bxl_ready got %b want 1", a_ready);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #3;
    n_checks++;
    if ({a_valid, a_operand, a_op1, a_op2, a_opn, a_wr, a_ill} !==
        {1'b1, 3'd5, 2'd1, 2'd3, 2'd1, 5'b00010, 1'b0}) begin
      n_fail++;
      $display("FAIL bxl_head got v%b opr%0d %0d/%0d/%0d wr%b il%b want v1 opr5 1/3/1 wr00010 il0",
               a_valid, a_operand, a_op1, a_op2, a_opn, a_wr, a_ill);
    end
    tick();
    drain();
  endtask

  task automatic test_stall();
    int got[$];
    drive(1, 1, 1, 0, 0);
    tick();
    drive(1, 4, 2, 0, 0);
    tick();
    drive(1, 3, 6, 0, 0);
    #3;
    n_checks++;
    if (a_ready !== 1'b0 || a_occ !== 2'd2) begin
      n_fail++;
      $display("FAIL stall_full got ready%b occ%0d want ready0 occ2", a_ready, a_occ);
    end
    tick();
    drive(1, 3, 6, 1, 0);
    for (int i = 0; i < 6; i++) begin
      #3;
      n_checks++;
      if (obs_a !== expect_bundle(1)) begin
        n_fail++;
        $display("FAIL stall_drain got %h want %h", obs_a, expect_bundle(1));
      end
      if (a_valid) got.push_back(int'(a_operand));
      tick();
      drive(0, 0, 0, 1, 0);
    end
    n_checks++;
    if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 6) begin
      n_fail++;
      $display("FAIL stall_order got %p want '{1,2,6}", got);
    end
  endtask

  task automatic test_full_push_pop();
    drain();
    drive(1, 2, 3, 0, 0);
    tick();
    drive(1, 5, 4, 0, 0);
    tick();
    drive(1, 6, 3, 1, 0);
    #3;
    n_checks++;
    if (a_ready !== 1'b1 || a_occ !== 2'd2) begin
      n_fail++;
      $display("FAIL pp_pre got ready%b occ%0d want ready1 occ2", a_ready, a_occ);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #3;
    n_checks++;
    if (a_occ !== 2'd2 || a_operand !== 3'd4) begin
      n_fail++;
      $display("FAIL pp_post got occ%0d opr%0d want occ2 opr4", a_occ, a_operand);
    end
    n_checks++;
    if (obs_a !== expect_bundle(1)) begin
      n_fail++;
      $display("FAIL pp_model got %h want %h", obs_a, expect_bundle(1));
    end
  endtask

  task automatic test_flush();
    drive(1, 0, 4, 1, 1);
    #3;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready got %b want 1", a_ready);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #3;
    n_checks++;
    if (a_occ !== 2'd0 || a_valid !== 1'b0 || b_occ !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_empty got occ%0d/%0d v%b want occ0/0 v0", a_occ, b_occ, a_valid);
    end
    tick();
    #3;
    n_checks++;
    if (a_occ !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_nopush got occ%0d want 0", a_occ);
    end
    tick();
  endtask

  task automatic test_illegal_sticky();
    drive(1, 5, 7, 1, 0);
    tick();
    drive(1, 4, 3, 1, 0);
    #3;
    n_checks++;
    if (a_valid !== 1'b1 || a_ill !== 1'b1 || a_wr !== 5'd0) begin
      n_fail++;
      $display("FAIL out7_illegal got v%b il%b wr%b want v1 il1 wr00000", a_valid, a_ill, a_wr);
    end
    tick();
    drive(1, 0, 2, 1, 0);
    #3;
    n_checks++;
    if (obs_a !== expect_bundle(1)) begin
      n_fail++;
      $display("FAIL bxc_head got %h want %h", obs_a, expect_bundle(1));
    end
    tick();
    drive(0, 0, 0, 1, 0);
    #3;
    n_checks++;
    if ({a_op1, a_op2, a_opn, a_wr} !== {2'd1, 2'd2, 2'd0, 5'b00001}) begin
      n_fail++;
      $display("FAIL adv_sticky got %0d/%0d/%0d wr%b want 1/2/0 wr00001", a_op1, a_op2, a_opn, a_wr);
    end
    n_checks++;
    if (b_op1 !== 2'd0 || b_op2 !== 2'd0) begin
      n_fail++;
      $display("FAIL adv_nosticky got %0d/%0d want 0/0", b_op1, b_op2);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drain();
    drive(1, 4, 1, 0, 0);
    tick();
    drive(1, 7, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (a_occ !== 2'd0 || a_valid !== 1'b0 || b_occ !== 2'd0) begin
      n_fail++;
      $display("FAIL areset got occ%0d/%0d v%b want occ0/0 v0", a_occ, b_occ, a_valid);
    end
    tick();
    rst_n = 1'b1;
    drive(1, 6, 3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #3;
    n_checks++;
    if ({a_op1, a_op2, a_opn, a_wr} !== {2'd0, 2'd0, 2'd0, 5'b00010}) begin
      n_fail++;
      $display("FAIL areset_sticky got %0d/%0d/%0d wr%b want 0/0/0 wr00010", a_op1, a_op2, a_opn, a_wr);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 8),
            ($urandom % 3) != 0, ($urandom % 20) == 0);
      #3;
      n_checks++;
      if (obs_a !== expect_bundle(1)) begin
        n_fail++;
        $display("FAIL rand_sticky cyc%0d got %h want %h", i, obs_a, expect_bundle(1));
      end
      n_checks++;
      if (obs_b !== expect_bundle(0)) begin
        n_fail++;
        $display("FAIL rand_plain cyc%0d got %h want %h", i, obs_b, expect_bundle(0));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bxl();
    test_stall();
    test_full_push_pop();
    test_flush();
    test_illegal_sticky();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
